// File: rtl/dynamic_pattern_gen.sv
// ----------------------------------------------------------------------------
// dynamic_pattern_gen
//
// Transmit-side partner of the dynamic pattern detector. Serialises the low
// `len` bits of a programmable pattern, MSB of the active length first, onto
// a d/v serial stream. A transfer can be repeated with a programmable number
// of idle cycles between bursts, and the sink can stall the stream via rdy_i.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   start_i  in   one-cycle request, only honoured while idle (busy_o=0)
//   pat_i    in   pattern, bits [len-1:0] are sent
//   len_i    in   pattern length in bits (clamped to PAT_W, 0 = send nothing)
//   rep_i    in   extra repetitions (total bursts = rep_i + 1)
//   gap_i    in   idle cycles between bursts
//   rdy_i    in   sink ready; a bit transfers when v_o && rdy_i
//   d_o      out  serial data (registered)
//   v_o      out  data valid (registered)
//   busy_o   out  high from the cycle after an accepted start through DONE
//   done_o   out  one-cycle completion pulse
//
// Build option:
//   GEN_GAP_PRBS_EN  when defined, gap cycles carry valid PRBS noise from a
//                    7-bit LFSR (x^7 + x^6 + 1) instead of an idle d=0/v=0.
// ----------------------------------------------------------------------------
module dynamic_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [REP_W-1:0] rep_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             rdy_i,
    output logic             d_o,
    output logic             v_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [LEN_W-1:0] bitIdx_q, bitIdx_d;
    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
    logic [PAT_W-1:0] pat_q,    pat_d;
    logic [LEN_W-1:0] len_q,    len_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic             dOut_d,   vOut_d;
    logic             busy_d,   done_d;

    logic [LEN_W-1:0] lenClamped;
    logic [PAT_W-1:0] patShifted;

    // Lengths beyond the pattern register are clamped so the transfer never
    // indexes past the top of the latched pattern.
    assign lenClamped = (len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_i;

    // Next-state logic. Every field is latched when a start is accepted so
    // that later changes on the inputs cannot disturb a running transfer.
    always_comb begin
        state_d  = state_q;
        bitIdx_d = bitIdx_q;
        repCnt_d = repCnt_q;
        gapCnt_d = gapCnt_q;
        pat_d    = pat_q;
        len_d    = len_q;
        gap_d    = gap_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    pat_d    = pat_i;
                    len_d    = lenClamped;
                    repCnt_d = rep_i;
                    gap_d    = gap_i;
                    if (lenClamped == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StSend;
                        bitIdx_d = lenClamped - LEN_W'(1);
                    end
                end
            end

            StSend: begin
                // A bit only moves on when the sink accepts it; otherwise the
                // same bit is simply presented again.
                if (rdy_i) begin
                    if (bitIdx_q == '0) begin
                        if (repCnt_q != '0) begin
                            repCnt_d = repCnt_q - REP_W'(1);
                            if (gap_q != '0) begin
                                state_d  = StGap;
                                gapCnt_d = gap_q - GAP_W'(1);
                            end else begin
                                bitIdx_d = len_q - LEN_W'(1);
                            end
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q - LEN_W'(1);
                    end
                end
            end

            StGap: begin
                // The gap is a fixed number of cycles regardless of rdy_i.
                if (gapCnt_q == '0) begin
                    state_d  = StSend;
                    bitIdx_d = len_q - LEN_W'(1);
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Shifting rather than bit-selecting keeps the index width independent
    // of the pattern width.
    assign patShifted = pat_d >> bitIdx_d;

`ifdef GEN_GAP_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d;

    // The noise source only advances on gap cycles the sink actually takes,
    // and keeps running across bursts so consecutive gaps differ.
    always_comb begin
        lfsr_d = lfsr_q;
        if ((state_q == StGap) && rdy_i) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 7'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        vOut_d = 1'b0;
        dOut_d = 1'b0;
        if (state_d == StSend) begin
            vOut_d = 1'b1;
            dOut_d = patShifted[0];
        end else if (state_d == StGap) begin
            vOut_d = 1'b1;
            dOut_d = lfsr_d[0];
        end
    end
`else
    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        vOut_d = 1'b0;
        dOut_d = 1'b0;
        if (state_d == StSend) begin
            vOut_d = 1'b1;
            dOut_d = patShifted[0];
        end
    end
`endif

    assign busy_d = (state_d != StIdle);
    assign done_d = (state_d == StDone);

    // State, latched fields and registered outputs. Reset aborts any transfer
    // immediately without a completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            bitIdx_q <= '0;
            repCnt_q <= '0;
            gapCnt_q <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            d_o      <= 1'b0;
            v_o      <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitIdx_q <= bitIdx_d;
            repCnt_q <= repCnt_d;
            gapCnt_q <= gapCnt_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            d_o      <= dOut_d;
            v_o      <= vOut_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end

endmodule
